// File: rtl/detect_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// detect_seq_ctrl_pkg
//
// Purpose:
//   Shared definitions for the word-level repeated-bit sequence detector.
//   It holds the controller state encoding, the default word and count
//   widths, and a small helper that sizes counters.
//
// Contents:
//   state_t      : controller FSM states (IDLE, SHIFT, DONE)
//   DEF_W        : default input word width
//   DEF_CW       : default match-count width
//   count_width  : number of bits needed to hold the value n
// ---------------------------------------------------------------------------
package detect_seq_ctrl_pkg;

    // Controller states. The encoding is fixed so that waveforms and
    // debug probes from other blocks decode the same way.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Default geometry: an 8-bit word with a 4-bit match count. The count
    // can reach W when chaining is enabled, so 2**DEF_CW must exceed DEF_W.
    localparam int DEF_W  = 8;
    localparam int DEF_CW = 4;

    // Number of bits needed to represent the unsigned value n. A zero or
    // one still needs a single bit, so the result is never below 1.
    function automatic int count_width(input int n);
        int bits;
        bits = 1;
        while ((n >> bits) != 0) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/detect_seq_ctrl_pair.sv
// ---------------------------------------------------------------------------
// seq_pair_det
//
// Purpose:
//   Per-bit pair detector for the serial datapath. Each enabled cycle it
//   compares the incoming bit with the bit it saw on the previous enabled
//   cycle. It then remembers the incoming bit for the next comparison.
//   A history-valid flag stops the very first bit after a clear (or reset)
//   from matching against stale or undefined history.
//
// Ports:
//   ck      in   clock, all state changes on the rising edge
//   rst_n   in   asynchronous active-low reset, clears history
//   clr     in   synchronous history clear (drops the history-valid flag)
//   en      in   consume bit_in this cycle and update history
//   bit_in  in   serial bit under test
//   match   out  combinational: history valid and bit_in equals previous
// ---------------------------------------------------------------------------
module seq_pair_det (
    input  logic ck,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic match
);

    logic prev_bit;
    logic hist_valid;

    // The match is purely combinational so the controller can record it in
    // the same cycle that the bit is consumed.
    assign match = hist_valid && (bit_in == prev_bit);

    // History registers. If clear and enable arrive together, clear wins,
    // which keeps a freshly accepted word from inheriting history. The
    // controller never raises both at once.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            prev_bit   <= 1'b0;
            hist_valid <= 1'b0;
        end else if (clr) begin
            prev_bit   <= 1'b0;
            hist_valid <= 1'b0;
        end else if (en) begin
            prev_bit   <= bit_in;
            hist_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/detect_seq_ctrl.sv
// ---------------------------------------------------------------------------
// detect_seq_ctrl
//
// Purpose:
//   Word-level controller for the repeated-bit sequence detector. It
//   accepts a W-bit word over a valid/ready handshake and shifts it LSB
//   first through seq_pair_det, one bit per clock. It then presents a
//   per-bit match mask and a match count over a second valid/ready
//   handshake. Each word takes exactly W SHIFT cycles, and a result stays
//   in DONE until the consumer takes it.
//
// Parameters:
//   W    input word width (2..32)
//   CW   match-count width, 2**CW > W so the count never wraps
//
// Ports:
//   ck         in   clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   producer has a word
//   in_ready   out  controller can accept a word (state IDLE)
//   in_data    in   word to scan, bit 0 scanned first
//   out_valid  out  result available (state DONE)
//   out_ready  in   consumer accepts the result
//   out_mask   out  bit i set when bit i equals bit i-1
//   out_count  out  number of ones in out_mask
//   out_hit    out  out_count is non-zero
//   busy       out  state is SHIFT or DONE
//
// Build option:
//   DETECT_SEQ_CTRL_CHAIN_EN
//     defined   : detector history carries over from one word to the next,
//                 so bit 0 is compared with bit W-1 of the previous word.
//                 Only rst_n clears the history.
//     undefined : history is cleared on every acceptance and out_mask[0]
//                 is always 0.
// ---------------------------------------------------------------------------
module detect_seq_ctrl
    import detect_seq_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_mask,
    output logic [CW-1:0] out_count,
    output logic          out_hit,
    output logic          busy
);

    // The bit index only needs to reach W-1.
    localparam int IW = count_width(W - 1);

    state_t          state;
    logic [W-1:0]    shreg;
    logic [W-1:0]    mask;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   count;

    logic            det_clr;
    logic            det_en;
    logic            det_match;

    // The detector consumes the shift-register LSB on every SHIFT cycle.
    // That bit is always bit idx of the captured word.
    assign det_en = (state == SHIFT);

`ifdef DETECT_SEQ_CTRL_CHAIN_EN
    // Chaining: history survives acceptance, and only rst_n clears it.
    assign det_clr = 1'b0;
`else
    // Every accepted word starts with empty history, so bit 0 cannot match.
    assign det_clr = (state == IDLE) && in_valid;
`endif

    seq_pair_det u_pair_det (
        .ck     (ck),
        .rst_n  (rst_n),
        .clr    (det_clr),
        .en     (det_en),
        .bit_in (shreg[0]),
        .match  (det_match)
    );

    // Main sequencer. IDLE waits for a word and captures it. SHIFT walks
    // through the W bits and records matches. DONE holds the result until
    // the consumer takes it. mask and count are not cleared on the way
    // back to IDLE, so the last result stays readable until the next
    // acceptance.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            mask  <= '0;
            idx   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        mask  <= '0;
                        count <= '0;
                        idx   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (det_match) begin
                        mask[idx] <= 1'b1;
                        count     <= count + CW'(1);
                    end
                    shreg <= shreg >> 1;
                    idx   <= idx + IW'(1);
                    if (idx == IW'(W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The handshake and status outputs are decoded from the state register
    // only, so there is no combinational path from in_valid or out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT) || (state == DONE);
    assign out_mask  = mask;
    assign out_count = count;
    assign out_hit   = |count;

endmodule

// File: tb/tb_detect_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_detect_seq_ctrl
//
// Directed bench for detect_seq_ctrl with W=8, CW=4. It drives words
// through the input handshake and compares the result handshake against
// hand-computed masks and counts. It also covers the DONE hold, an
// asynchronous reset in the middle of a scan, and back-to-back
// throughput. The expected values follow DETECT_SEQ_CTRL_CHAIN_EN in the
// same way as the design.
// ---------------------------------------------------------------------------
module tb_detect_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          ck = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_mask;
    logic [CW-1:0] out_count;
    logic          out_hit;
    logic          busy;

    int passCount  = 0;
    int checkCount = 0;

    detect_seq_ctrl #(.W(W), .CW(CW)) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_hit   (out_hit),
        .busy      (busy)
    );

    // Free-running clock with a 10-unit period.
    always #5 ck = ~ck;

    // Single comparison point. Every check is counted here, and every
    // mismatch is reported here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Waits for out_valid after a word was driven at the current negedge.
    // lat counts rising edges after the acceptance edge. The wait is
    // bounded, so a stuck DUT shows up as a latency failure.
    task automatic waitResult(output int lat);
        lat = 0;
        @(negedge ck);
        in_valid = 1'b0;
        while (!out_valid && lat < 4 * W) begin
            @(negedge ck);
            lat++;
        end
    endtask

    // Sends one word and checks latency and the result. It then completes
    // the output handshake and checks that the result stays visible in IDLE.
    task automatic applyStimulus(input string tag, input logic [W-1:0] word,
                                 input logic [W-1:0] expMask,
                                 input logic [CW-1:0] expCount,
                                 input logic expHit);
        int lat;
        checkOutput({tag, " in_ready before"}, in_ready, 1);
        in_data  = word;
        in_valid = 1'b1;
        waitResult(lat);
        checkOutput({tag, " latency"}, lat, W);
        checkOutput({tag, " mask"}, out_mask, expMask);
        checkOutput({tag, " count"}, out_count, expCount);
        checkOutput({tag, " hit"}, out_hit, expHit);
        out_ready = 1'b1;
        @(negedge ck);
        out_ready = 1'b0;
        checkOutput({tag, " out_valid after"}, out_valid, 0);
        checkOutput({tag, " mask kept in IDLE"}, out_mask, expMask);
    endtask

`ifdef DETECT_SEQ_CTRL_CHAIN_EN
    localparam logic [W-1:0]  SECOND01_MASK = 8'hFD;
    localparam logic [CW-1:0] SECOND01_CNT  = 4'd7;
    localparam logic [W-1:0]  LATER_B3_MASK = 8'h2B;
    localparam logic [CW-1:0] LATER_B3_CNT  = 4'd4;
`else
    localparam logic [W-1:0]  SECOND01_MASK = 8'hFC;
    localparam logic [CW-1:0] SECOND01_CNT  = 4'd6;
    localparam logic [W-1:0]  LATER_B3_MASK = 8'h2A;
    localparam logic [CW-1:0] LATER_B3_CNT  = 4'd3;
`endif

    // Safety net in case something above hangs despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        int readyCycles;
        int hits[$];

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #1 rst_n  = 1'b0;
        #10;
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset mask", out_mask, 0);
        checkOutput("reset count", out_count, 0);
        checkOutput("reset hit", out_hit, 0);
        checkOutput("reset busy", busy, 0);
        @(negedge ck);
        rst_n = 1'b1;
        @(negedge ck);

        // The words are ordered so that the chained build gives the same
        // results as the unchained build, except for the second word of
        // the 80/01 pair.
        applyStimulus("w55", 8'h55, 8'h00, 4'd0, 1'b0);
        applyStimulus("wB3", 8'hB3, 8'h2A, 4'd3, 1'b1);
        applyStimulus("w80", 8'h80, 8'h7E, 4'd6, 1'b1);
        applyStimulus("w01", 8'h01, SECOND01_MASK, SECOND01_CNT, 1'b1);
        applyStimulus("wFF", 8'hFF, 8'hFE, 4'd7, 1'b1);

        // DONE hold: out_ready stays low for 5 cycles. A stray in_valid
        // carrying different data must change nothing.
        in_data  = 8'hF0;
        in_valid = 1'b1;
        waitResult(lat);
        checkOutput("hold latency", lat, W);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 1);
            in_data  = 8'hFF;
            @(negedge ck);
            checkOutput("hold out_valid", out_valid, 1);
            checkOutput("hold mask", out_mask, 8'hEE);
            checkOutput("hold count", out_count, 6);
            checkOutput("hold in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge ck);
        out_ready = 1'b0;
        checkOutput("hold release in_ready", in_ready, 1);
        checkOutput("hold release mask", out_mask, 8'hEE);

        // Asynchronous reset in the middle of the third SHIFT cycle.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(negedge ck);
        in_valid = 1'b0;
        @(negedge ck);
        @(negedge ck);
        checkOutput("pre-reset busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset in_ready", in_ready, 1);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset mask", out_mask, 0);
        checkOutput("async reset count", out_count, 0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            if (out_valid) seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge ck);
            if (out_valid) seen++;
        end
        checkOutput("no partial out_valid", seen, 0);
        applyStimulus("post-reset w01", 8'h01, 8'hFC, 4'd6, 1'b1);

        // Throughput with in_valid and out_ready held high the whole time.
        in_data     = 8'hB3;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        readyCycles = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge ck);
            if (in_ready) begin
                readyCycles++;
                checkOutput("stream in_ready only in IDLE", busy, 0);
            end
            if (out_valid) begin
                hits.push_back(c);
                if (hits.size() == 1) begin
                    checkOutput("stream first mask", out_mask, 8'h2A);
                end else begin
                    checkOutput("stream later mask", out_mask, LATER_B3_MASK);
                    checkOutput("stream later count", out_count, LATER_B3_CNT);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("stream result count", hits.size(), 3);
        checkOutput("stream in_ready cycles", readyCycles, 3);
        if (hits.size() >= 3) begin
            checkOutput("stream first latency", hits[0], W);
            checkOutput("stream period 1", hits[1] - hits[0], W + 2);
            checkOutput("stream period 2", hits[2] - hits[1], W + 2);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
